// File: rtl/knn_local_buf_ctrl.sv
// Local buffer controller: fills a 1R1W memory from a stream, then drains it in order
// through a small output FIFO sized so that no returning read word is ever dropped.
module knn_local_buf_ctrl #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int AddressRange = 2048,
  parameter int ReadLatency  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AddressWidth:0]   len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DataWidth-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DataWidth-1:0]    out_data,
  output logic                    busy,
  output logic                    done,
  output logic [AddressWidth-1:0] address0,
  output logic                    ce0,
  output logic                    we0,
  output logic [DataWidth-1:0]    d0,
  input  logic [DataWidth-1:0]    q0
);

  localparam int LenWidth  = AddressWidth + 1;
  localparam int FifoDepth = ReadLatency + 2;
  localparam int PtrWidth  = $clog2(FifoDepth);
  localparam int CntWidth  = $clog2(2 * FifoDepth + 1);
  localparam logic [LenWidth-1:0] RangeL  = LenWidth'(AddressRange);
  localparam logic [LenWidth-1:0] OneL    = {{(LenWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] OneC    = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] DepthC  = CntWidth'(FifoDepth);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(FifoDepth - 1);
  localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [LenWidth-1:0]    len_clip_s, last_r, wr_cnt_r, rd_cnt_r, pop_cnt_r;
  logic [ReadLatency:0]   pipe_r;
  logic [DataWidth-1:0]   fifo_mem_r [FifoDepth];
  logic [PtrWidth-1:0]    wptr_r, rptr_r;
  logic [CntWidth-1:0]    occ_r, inflight_s;
  logic                   accept_s, issue_s, push_s, pop_s, done_s, credit_s;
  logic                   ce0_r, we0_r, in_ready_r, busy_r, done_r;
  logic [AddressWidth-1:0] address0_r;
  logic [DataWidth-1:0]   d0_r;

  assign len_clip_s = (len > RangeL) ? RangeL : len;
  assign push_s     = pipe_r[ReadLatency];
  assign out_valid  = (occ_r != {CntWidth{1'b0}});
  assign out_data   = fifo_mem_r[rptr_r];
  assign pop_s      = out_valid & out_ready;
  // A pop this cycle frees a slot before the new read could ever land, so it is credited.
  assign credit_s   = ((occ_r + inflight_s - (pop_s ? OneC : {CntWidth{1'b0}})) < DepthC);

  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign address0 = address0_r;
  assign ce0      = ce0_r;
  assign we0      = we0_r;
  assign d0       = d0_r;

  // Count reads issued whose data has not yet been pushed into the FIFO.
  always_comb begin
    inflight_s = {CntWidth{1'b0}};
    for (int i = 0; i <= ReadLatency; i++) begin
      inflight_s = inflight_s + CntWidth'(pipe_r[i]);
    end
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    issue_s  = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len_clip_s != {LenWidth{1'b0}}) begin
            state_s = FILL;
          end else begin
            state_s = IDLE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (in_valid && in_ready_r) begin
          accept_s = 1'b1;
          if (wr_cnt_r == last_r) begin
            state_s = DRAIN;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      DRAIN: begin
        if (credit_s) begin
          issue_s = 1'b1;
          if (rd_cnt_r == last_r) begin
            state_s = FLUSH;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      FLUSH: begin
        if (pop_s && (pop_cnt_r == last_r)) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, job counters, memory-port drive and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      last_r     <= {LenWidth{1'b0}};
      wr_cnt_r   <= {LenWidth{1'b0}};
      rd_cnt_r   <= {LenWidth{1'b0}};
      pop_cnt_r  <= {LenWidth{1'b0}};
      ce0_r      <= 1'b0;
      we0_r      <= 1'b0;
      address0_r <= {AddressWidth{1'b0}};
      d0_r       <= {DataWidth{1'b0}};
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == FILL);
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
      if (accept_s) begin
        ce0_r      <= 1'b1;
        we0_r      <= 1'b1;
        address0_r <= wr_cnt_r[AddressWidth-1:0];
        d0_r       <= in_data;
      end else if (issue_s) begin
        ce0_r      <= 1'b1;
        we0_r      <= 1'b0;
        address0_r <= rd_cnt_r[AddressWidth-1:0];
      end else begin
        ce0_r <= 1'b0;
        we0_r <= 1'b0;
      end
      if ((state_r == IDLE) && start) begin
        last_r    <= len_clip_s - OneL;
        wr_cnt_r  <= {LenWidth{1'b0}};
        rd_cnt_r  <= {LenWidth{1'b0}};
        pop_cnt_r <= {LenWidth{1'b0}};
      end else begin
        if (accept_s) wr_cnt_r  <= wr_cnt_r + OneL;
        if (issue_s)  rd_cnt_r  <= rd_cnt_r + OneL;
        if (pop_s)    pop_cnt_r <= pop_cnt_r + OneL;
      end
    end
  end

  // Read-return tracking and FIFO pointers; reset discards anything still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_r <= {(ReadLatency+1){1'b0}};
      wptr_r <= {PtrWidth{1'b0}};
      rptr_r <= {PtrWidth{1'b0}};
      occ_r  <= {CntWidth{1'b0}};
    end else begin
      pipe_r[0] <= issue_s;
      for (int i = 1; i <= ReadLatency; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      if (push_s) wptr_r <= (wptr_r == PtrLast) ? {PtrWidth{1'b0}} : wptr_r + PtrOne;
      if (pop_s)  rptr_r <= (rptr_r == PtrLast) ? {PtrWidth{1'b0}} : rptr_r + PtrOne;
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OneC;
        2'b01:   occ_r <= occ_r - OneC;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // FIFO storage captures the returned memory word.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wptr_r] <= q0;
  end

endmodule

// File: tb/tb_knn_local_buf_ctrl.sv
// Bench for knn_local_buf_ctrl: memory model with two-cycle read latency, event logs
// collected each cycle, and per-scenario checks against the first L beats sent.
module tb_knn_local_buf_ctrl;
  localparam int DW = 256;
  localparam int AW = 11;
  localparam int AR = 2048;
  localparam int RL = 2;
  localparam int DEPTH = RL + 2;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, in_valid, in_ready, out_valid, out_ready, busy, done, ce0, we0;
  logic [AW:0] len;
  logic [DW-1:0] in_data, out_data, d0, q0;
  logic [AW-1:0] address0;

  knn_local_buf_ctrl #(.DataWidth(DW), .AddressWidth(AW), .AddressRange(AR), .ReadLatency(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done),
    .address0(address0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0)
  );

  logic [DW-1:0] mem [0:AR-1];
  logic [DW-1:0] rd1, rd2;
  assign q0 = rd2;
  always @(posedge clk) begin
    if (ce0 && we0) mem[address0] <= d0;
    rd1 <= mem[address0];
    rd2 <= rd1;
  end

  int total = 0, bad = 0;
  int wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int rd_addr_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] beats[$];
  int done_cnt, ce_cnt, max_outst, stab_viol, cyc, first_pop, last_pop;
  bit busy_seen, hold_prev;
  logic [DW-1:0] held;

  initial begin
    cyc = 0; hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (ce0 && we0) begin wr_addr_q.push_back(int'(address0)); wr_data_q.push_back(d0); end
        if (ce0 && !we0) rd_addr_q.push_back(int'(address0));
        if (ce0) ce_cnt++;
        if (busy) busy_seen = 1'b1;
        if (done) done_cnt++;
        if (rd_addr_q.size() - out_q.size() > max_outst) max_outst = rd_addr_q.size() - out_q.size();
        if (hold_prev && (!out_valid || out_data !== held)) stab_viol++;
        if (out_valid && out_ready) begin
          out_q.push_back(out_data);
          if (out_q.size() == 1) first_pop = cyc;
          last_pop = cyc;
        end
        hold_prev = out_valid && !out_ready;
        held = out_data;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); out_q.delete();
    done_cnt = 0; ce_cnt = 0; max_outst = 0; stab_viol = 0; busy_seen = 1'b0;
    first_pop = 0; last_pop = 0;
  endtask

  task automatic gen_beats(input int n, input bit fixed);
    beats.delete();
    for (int i = 0; i < n; i++) begin
      if (fixed) beats.push_back(DW'(32'hA + i));
      else beats.push_back({$urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom()});
    end
  endtask

  // Writes must be beats 0..L-1 at addresses 0..L-1, reads 0..L-1, outputs beats 0..L-1.
  task automatic count_errs(input int l, output int we, output int re, output int oe);
    we = (wr_addr_q.size() == l) ? 0 : 1;
    re = (rd_addr_q.size() == l) ? 0 : 1;
    oe = (out_q.size() == l) ? 0 : 1;
    for (int i = 0; i < l && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] != i || wr_data_q[i] !== beats[i]) we++;
    for (int i = 0; i < l && i < rd_addr_q.size(); i++)
      if (rd_addr_q[i] != i) re++;
    for (int i = 0; i < l && i < out_q.size(); i++)
      if (out_q[i] !== beats[i]) oe++;
  endtask

  task automatic run_job(input int n, input int vpct, input int rpct, input int stall_after,
                         input int stall_len, input int restart_at, output bit to);
    int idx = 0, cycles = 0, stalled = 0;
    bit acc, restarted = 1'b0;
    clear_logs();
    start = 1'b1; len = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == 0 && cycles < 20000) begin
      in_valid = (idx < beats.size()) && ($urandom_range(99) < vpct);
      if (idx < beats.size()) in_data = beats[idx];
      if (restart_at >= 0 && idx == restart_at && !restarted) begin
        start = 1'b1; len = (AW+1)'(3); restarted = 1'b1;
      end else start = 1'b0;
      if (out_q.size() >= stall_after && stalled < stall_len) begin
        out_ready = 1'b0; stalled++;
      end else out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cycles++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    to = (done_cnt == 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [AW+DW+5:0] v;
    repeat (3) @(posedge clk);
    #1;
    v = {address0, ce0, we0, d0, in_ready, out_valid, busy, done};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", v); end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    bit to; int we, re, oe;
    gen_beats(4, 1'b1);
    run_job(4, 100, 100, BIG, 0, -1, to);
    count_errs(4, we, re, oe);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%0b want=0", to); end
    total++; if (we != 0) begin bad++; $display("FAIL basic_writes errors=%0d want=0", we); end
    total++; if (re != 0) begin bad++; $display("FAIL basic_reads errors=%0d want=0", re); end
    total++; if (oe != 0) begin bad++; $display("FAIL basic_outputs errors=%0d want=0", oe); end
    total++; if (done_cnt != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_done pulses=%0d busy=%b want 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    start = 1'b1; len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_done done=%b busy=%b want 1 0", done, busy);
    end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width done=%b want 0", done); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ce_cnt != 0 || busy_seen || done_cnt != 1) begin
      bad++; $display("FAIL zero_quiet ce=%0d busy_seen=%0b done=%0d want 0 0 1", ce_cnt, busy_seen, done_cnt);
    end
  endtask

  task automatic test_clamp();
    bit to; int we, re, oe, lastw;
    gen_beats(4000, 1'b0);
    run_job(4000, 100, 100, BIG, 0, -1, to);
    count_errs(AR, we, re, oe);
    lastw = (wr_addr_q.size() > 0) ? wr_addr_q[$] : -1;
    total++; if (to !== 1'b0) begin bad++; $display("FAIL clamp_timeout got=%0b want=0", to); end
    total++; if (we != 0 || lastw != AR - 1) begin
      bad++; $display("FAIL clamp_writes errors=%0d last=%0d want 0 %0d", we, lastw, AR - 1);
    end
    total++; if (re != 0 || oe != 0) begin
      bad++; $display("FAIL clamp_drain rd_err=%0d out_err=%0d want 0 0", re, oe);
    end
    total++; if (last_pop - first_pop != AR - 1) begin
      bad++; $display("FAIL clamp_throughput span=%0d want=%0d", last_pop - first_pop, AR - 1);
    end
    total++; if (max_outst > DEPTH) begin
      bad++; $display("FAIL clamp_buffer max=%0d want<=%0d", max_outst, DEPTH);
    end
  endtask

  task automatic test_backpressure();
    bit to; int we, re, oe;
    gen_beats(16, 1'b0);
    run_job(16, 100, 100, 3, 20, -1, to);
    count_errs(16, we, re, oe);
    total++; if (to !== 1'b0 || we + re + oe != 0) begin
      bad++; $display("FAIL bp_data to=%0b errors=%0d want 0 0", to, we + re + oe);
    end
    total++; if (max_outst != DEPTH) begin
      bad++; $display("FAIL bp_buffer max=%0d want=%0d", max_outst, DEPTH);
    end
    total++; if (stab_viol != 0) begin
      bad++; $display("FAIL bp_stable violations=%0d want=0", stab_viol);
    end
  endtask

  task automatic test_restart_in_fill();
    bit to; int we, re, oe;
    gen_beats(6, 1'b0);
    run_job(6, 100, 100, BIG, 0, 2, to);
    count_errs(6, we, re, oe);
    total++; if (to !== 1'b0 || we + re + oe != 0) begin
      bad++; $display("FAIL restart_data to=%0b errors=%0d want 0 0", to, we + re + oe);
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done pulses=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_in_drain();
    bit to, acc; int we, re, oe, idx = 0, n = 0;
    logic [AW+DW+5:0] v;
    gen_beats(16, 1'b0);
    clear_logs();
    start = 1'b1; len = (AW+1)'(16);
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    while (n < 200) begin
      in_valid = (idx < 16);
      if (idx < 16) in_data = beats[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (rd_addr_q.size() >= 2) break;
      @(posedge clk); #1;
      if (acc) idx++;
      n++;
    end
    total++; if (rd_addr_q.size() != 2) begin
      bad++; $display("FAIL rst_drain_reach reads=%0d want=2", rd_addr_q.size());
    end
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    v = {address0, ce0, we0, d0, in_ready, out_valid, busy, done};
    total++; if (v !== '0) begin bad++; $display("FAIL rst_drain_outputs got=%h want=0", v); end
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    gen_beats(2, 1'b0);
    run_job(2, 100, 100, BIG, 0, -1, to);
    count_errs(2, we, re, oe);
    total++; if (to !== 1'b0 || oe != 0) begin
      bad++; $display("FAIL rst_drain_next to=%0b out_err=%0d outs=%0d want 0 0 2", to, oe, out_q.size());
    end
    total++; if (we + re != 0 || done_cnt != 1) begin
      bad++; $display("FAIL rst_drain_mem errors=%0d done=%0d want 0 1", we + re, done_cnt);
    end
  endtask

  task automatic test_random();
    bit to; int we, re, oe, n;
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(40, 1);
      gen_beats(n, 1'b0);
      run_job(n, $urandom_range(100, 50), $urandom_range(100, 50),
              $urandom_range(n, 0), $urandom_range(10, 0), -1, to);
      count_errs(n, we, re, oe);
      total++; if (to !== 1'b0 || we + re + oe != 0) begin
        bad++; $display("FAIL rand%0d_data len=%0d to=%0b errors=%0d want 0 0", j, n, to, we + re + oe);
      end
      total++; if (done_cnt != 1 || max_outst > DEPTH || stab_viol != 0) begin
        bad++; $display("FAIL rand%0d_ctrl done=%0d max=%0d stab=%0d want 1 <=%0d 0",
                        j, done_cnt, max_outst, stab_viol, DEPTH);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero_len();
    test_clamp();
    test_backpressure();
    test_restart_in_fill();
    test_reset_in_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
